// File: rtl/i2c_slave_wm8731.sv
// I2C responder emulating the WM8731 control port: device byte, 16-bit register
// pointer, then write bursts or sequential reads against a small register file.
`timescale 1ns/1ps

module i2c_slave_wm8731 #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         REG_NUM  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    localparam int          IDX_W     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [15:0] REG_LIMIT = 16'(REG_NUM);

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        ADDR_H,
        ADDR_H_ACK,
        ADDR_L,
        ADDR_L_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  scl_sync, sda_sync;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic        byte_full, byte_full_nxt;
    logic [7:0]  shift, shift_nxt;
    logic [15:0] ptr, ptr_nxt;
    logic        rw, rw_nxt;
    logic        sda_oe_nxt;
    logic        busy_nxt;
    logic        commit_pend, commit_nxt;
    logic [7:0]  regs [REG_NUM];

    logic        scl_rise, scl_fall, scl_high;
    logic        start_det, stop_det;
    logic        sda_bit;
    logic        ptr_in_range;
    logic [7:0]  rd_byte;
    logic [7:0]  shifted_in;

    // Stages [1:0] synchronize the pins; stage [2] is the previous value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value,
            // which is what makes this a shift chain rather than a single wire.
            scl_sync <= {scl_sync[1:0], scl_in};
            sda_sync <= {sda_sync[1:0], sda_in};
        end
    end

    assign scl_rise     = scl_sync[1] & ~scl_sync[2];
    assign scl_fall     = ~scl_sync[1] & scl_sync[2];
    assign scl_high     = scl_sync[1] & scl_sync[2];
    assign start_det    = scl_high & ~sda_sync[1] & sda_sync[2];
    assign stop_det     = scl_high & sda_sync[1] & ~sda_sync[2];
    assign sda_bit      = sda_sync[1];
    assign ptr_in_range = (ptr < REG_LIMIT);
    assign rd_byte      = ptr_in_range ? regs[ptr[IDX_W-1:0]] : 8'hFF;
    assign shifted_in   = {shift[6:0], sda_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            byte_full   <= 1'b0;
            shift       <= '0;
            ptr         <= '0;
            rw          <= 1'b0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            commit_pend <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            byte_full   <= byte_full_nxt;
            shift       <= shift_nxt;
            ptr         <= ptr_nxt;
            rw          <= rw_nxt;
            sda_oe      <= sda_oe_nxt;
            busy        <= busy_nxt;
            commit_pend <= commit_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        byte_full_nxt = byte_full;
        shift_nxt     = shift;
        ptr_nxt       = ptr;
        rw_nxt        = rw;
        sda_oe_nxt    = sda_oe;
        busy_nxt      = busy;
        commit_nxt    = 1'b0;

        if (start_det) begin
            state_nxt     = DEV;
            bit_cnt_nxt   = '0;
            byte_full_nxt = 1'b0;
            sda_oe_nxt    = 1'b0;
        end else if (stop_det) begin
            state_nxt     = IDLE;
            bit_cnt_nxt   = '0;
            byte_full_nxt = 1'b0;
            sda_oe_nxt    = 1'b0;
            busy_nxt      = 1'b0;
        end else begin
            case (state)
                DEV, ADDR_H, ADDR_L, WDATA: begin
                    if (scl_rise) begin
                        shift_nxt   = shifted_in;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_full_nxt = 1'b1;
                            commit_nxt    = (state == WDATA) && ptr_in_range;
                        end
                    end else if (scl_fall && byte_full) begin
                        // Falling edge after the 8th bit: decide ACK/NACK for this byte.
                        byte_full_nxt = 1'b0;
                        case (state)
                            DEV: begin
                                if (shift[7:1] == DEV_ADDR) begin
                                    state_nxt  = DEV_ACK;
                                    sda_oe_nxt = 1'b1;
                                    busy_nxt   = 1'b1;
                                    rw_nxt     = shift[0];
                                end else begin
                                    state_nxt  = IGNORE;
                                    sda_oe_nxt = 1'b0;
                                end
                            end
                            ADDR_H: begin
                                ptr_nxt[15:8] = shift;
                                state_nxt     = ADDR_H_ACK;
                                sda_oe_nxt    = 1'b1;
                            end
                            ADDR_L: begin
                                ptr_nxt[7:0] = shift;
                                state_nxt    = ADDR_L_ACK;
                                sda_oe_nxt   = 1'b1;
                            end
                            default: begin
                                if (ptr_in_range) begin
                                    state_nxt  = WDATA_ACK;
                                    sda_oe_nxt = 1'b1;
                                end else begin
                                    state_nxt  = IGNORE;
                                    sda_oe_nxt = 1'b0;
                                end
                            end
                        endcase
                    end
                end

                DEV_ACK: begin
                    if (scl_fall) begin
                        if (rw) begin
                            state_nxt  = RDATA;
                            shift_nxt  = rd_byte;
                            sda_oe_nxt = ~rd_byte[7];
                        end else begin
                            state_nxt  = ADDR_H;
                            sda_oe_nxt = 1'b0;
                        end
                    end
                end

                ADDR_H_ACK: begin
                    if (scl_fall) begin
                        state_nxt  = ADDR_L;
                        sda_oe_nxt = 1'b0;
                    end
                end

                ADDR_L_ACK: begin
                    if (scl_fall) begin
                        state_nxt  = WDATA;
                        sda_oe_nxt = 1'b0;
                    end
                end

                WDATA_ACK: begin
                    if (scl_fall) begin
                        state_nxt  = WDATA;
                        sda_oe_nxt = 1'b0;
                        ptr_nxt    = ptr + 16'd1;
                    end
                end

                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            byte_full_nxt = 1'b1;
                    end else if (scl_fall) begin
                        if (byte_full) begin
                            byte_full_nxt = 1'b0;
                            state_nxt     = RDATA_ACK;
                            sda_oe_nxt    = 1'b0;
                        end else begin
                            shift_nxt  = {shift[6:0], 1'b0};
                            sda_oe_nxt = ~shift[6];
                        end
                    end
                end

                RDATA_ACK: begin
                    // Master ACK advances the pointer early so the falling edge can load the next byte.
                    if (scl_rise) begin
                        if (sda_bit)
                            state_nxt = IGNORE;
                        else
                            ptr_nxt = ptr + 16'd1;
                    end else if (scl_fall) begin
                        state_nxt  = RDATA;
                        shift_nxt  = rd_byte;
                        sda_oe_nxt = ~rd_byte[7];
                    end
                end

                default: begin
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // Commit one clock after the 8th data bit lands in the shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is reset explicitly because reads must return
            // 0x00 after reset; this keeps it in flops rather than a RAM macro.
            for (int i = 0; i < REG_NUM; i++)
                regs[i] <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= commit_pend;
            if (commit_pend) begin
                regs[ptr[IDX_W-1:0]] <= shift;
                wr_addr              <= ptr;
                wr_data              <= shift;
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_wm8731.sv
// Directed bench for i2c_slave_wm8731: bit-banged I2C master with an open-drain
// line model, strobe/SDA monitors and hand-computed expectations.
`timescale 1ns/1ps

module tb_i2c_slave_wm8731;

    localparam int Q = 80;  // quarter SCL period in ns; SCL = 32 clk periods

    logic        clk;
    logic        rst_n;
    logic        scl_m;
    logic        sda_m;
    logic        sda_line;
    logic        sda_oe;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int wr_total = 0;
    int oe_total = 0;
    logic [15:0] addr_log [64];
    logic [7:0]  data_log [64];

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_wm8731 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_in  (scl_m),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (wr_en) begin
            addr_log[wr_total % 64] <= wr_addr;
            data_log[wr_total % 64] <= wr_data;
            wr_total <= wr_total + 1;
        end
        if (sda_oe)
            oe_total <= oe_total + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; #Q;
            scl_m = 1'b1; #(2*Q);
            scl_m = 1'b0; #Q;
        end
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        ack = sda_line; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic read_bits(input int n, output logic [7:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            sda_m = 1'b1; #Q;
            scl_m = 1'b1; #Q;
            v = {v[6:0], sda_line}; #Q;
            scl_m = 1'b0; #Q;
        end
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] v);
        read_bits(8, v);
        sda_m = nack; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    // acks = {dev, addr_h, addr_l, data0, data1}; unsent data1 reports 0
    task automatic write_txn(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1,
                             input int n, output logic [4:0] acks);
        logic a0, a1, a2, a3, a4;
        a4 = 1'b0;
        i2c_start();
        write_byte(8'h34, a0);
        write_byte(a[15:8], a1);
        write_byte(a[7:0], a2);
        write_byte(d0, a3);
        if (n > 1) write_byte(d1, a4);
        acks = {a0, a1, a2, a3, a4};
    endtask

    // acks = {dev_w, addr_h, addr_l, dev_r}; single byte read ended by NACK, then STOP
    task automatic read_reg(input logic [15:0] a, output logic [7:0] v, output logic [3:0] acks);
        logic a0, a1, a2, a3;
        i2c_start();
        write_byte(8'h34, a0);
        write_byte(a[15:8], a1);
        write_byte(a[7:0], a2);
        i2c_start();
        write_byte(8'h35, a3);
        read_byte(1'b1, v);
        i2c_stop();
        acks = {a0, a1, a2, a3};
    endtask

    initial begin
        logic [4:0] acks;
        logic [3:0] racks;
        logic [7:0] v;
        logic       a0, a1, a2, a3;
        int         wr_base, oe_base;

        rst_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        #100;
        check("reset_sda_oe", sda_oe, 1'b0);
        check("reset_wr_en", wr_en, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_wr_addr", wr_addr, 16'h0000);
        check("reset_wr_data", wr_data, 8'h00);
        rst_n = 1'b1;
        #200;

        // Single register write
        wr_base = wr_total;
        write_txn(16'h0008, 8'h15, 8'h00, 1, acks);
        check("wr1_acks", acks, 5'b00000);
        check("wr1_busy_before_stop", busy, 1'b1);
        i2c_stop();
        check("wr1_busy_after_stop", busy, 1'b0);
        check("wr1_strobe_count", wr_total - wr_base, 1);
        check("wr1_addr", addr_log[wr_base % 64], 16'h0008);
        check("wr1_data", data_log[wr_base % 64], 8'h15);
        check("wr1_wr_addr_held", wr_addr, 16'h0008);

        // Foreign device address is ignored
        wr_base = wr_total;
        oe_base = oe_total;
        i2c_start();
        write_byte(8'h36, a0);
        write_byte(8'h00, a1);
        write_byte(8'h08, a2);
        write_byte(8'h77, a3);
        check("foreign_acks", {a0, a1, a2, a3}, 4'b1111);
        check("foreign_busy", busy, 1'b0);
        i2c_stop();
        check("foreign_oe_cycles", oe_total - oe_base, 0);
        check("foreign_strobes", wr_total - wr_base, 0);

        wr_base = wr_total;
        write_txn(16'h0001, 8'h5A, 8'h00, 1, acks);
        i2c_stop();
        check("after_foreign_acks", acks, 5'b00000);
        check("after_foreign_strobes", wr_total - wr_base, 1);

        // Two-byte burst with pointer auto-increment
        wr_base = wr_total;
        write_txn(16'h000C, 8'h00, 8'hAA, 2, acks);
        i2c_stop();
        check("burst_acks", acks, 5'b00000);
        check("burst_strobes", wr_total - wr_base, 2);
        check("burst_addr0", addr_log[wr_base % 64], 16'h000C);
        check("burst_data0", data_log[wr_base % 64], 8'h00);
        check("burst_addr1", addr_log[(wr_base + 1) % 64], 16'h000D);
        check("burst_data1", data_log[(wr_base + 1) % 64], 8'hAA);

        // Random read: set pointer, repeated START, two sequential bytes
        i2c_start();
        write_byte(8'h34, a0);
        write_byte(8'h00, a1);
        write_byte(8'h0C, a2);
        i2c_start();
        write_byte(8'h35, a3);
        check("rd_acks", {a0, a1, a2, a3}, 4'b0000);
        read_byte(1'b0, v);
        check("rd_byte0", v, 8'h00);
        read_byte(1'b1, v);
        check("rd_byte1", v, 8'hAA);
        check("rd_sda_released", sda_oe, 1'b0);
        #(2*Q);
        check("rd_sda_still_released", sda_oe, 1'b0);
        i2c_stop();

        read_reg(16'h0008, v, racks);
        check("rd_0008_acks", racks, 4'b0000);
        check("rd_0008", v, 8'h15);
        read_reg(16'h0001, v, racks);
        check("rd_0001", v, 8'h5A);

        // Out-of-range write and read
        wr_base = wr_total;
        write_txn(16'h0100, 8'h55, 8'h00, 1, acks);
        i2c_stop();
        check("oor_acks", acks, 5'b00010);
        check("oor_strobes", wr_total - wr_base, 0);
        read_reg(16'h0100, v, racks);
        check("oor_read_acks", racks, 4'b0000);
        check("oor_read", v, 8'hFF);

        // Reset asserted during bit 4 of a read byte (0x000C holds 0x00, so SDA is driven low)
        i2c_start();
        write_byte(8'h34, a0);
        write_byte(8'h00, a1);
        write_byte(8'h0C, a2);
        i2c_start();
        write_byte(8'h35, a3);
        read_bits(3, v);
        check("rst_pre_bits", v, 8'h00);
        check("rst_pre_sda_oe", sda_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        #9;
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        rst_n = 1'b1;
        #(2*Q);
        check("rst_wr_addr", wr_addr, 16'h0000);
        check("rst_wr_data", wr_data, 8'h00);

        read_reg(16'h000D, v, racks);
        check("post_rst_acks", racks, 4'b0000);
        check("post_rst_reg_0d", v, 8'h00);
        read_reg(16'h0008, v, racks);
        check("post_rst_reg_08", v, 8'h00);

        wr_base = wr_total;
        write_txn(16'h0003, 8'h3C, 8'h00, 1, acks);
        i2c_stop();
        check("post_rst_wr_acks", acks, 5'b00000);
        check("post_rst_strobes", wr_total - wr_base, 1);
        check("post_rst_addr", addr_log[wr_base % 64], 16'h0003);
        check("post_rst_data", data_log[wr_base % 64], 8'h3C);
        read_reg(16'h0003, v, racks);
        check("post_rst_readback", v, 8'h3C);
        check("post_rst_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_slave_wm8731.md
Name: i2c_slave_wm8731

Overview:
- Synthesizable I2C responder that emulates the codec end of the WM8731 configuration bus.
- Accepts the 4-byte write words the config master issues: device byte 0x34, 16-bit register address, 8-bit data.
- Stores written bytes in an internal register file, supports readback, and emits a write strobe.
- Used as an on-FPGA loopback target for bring-up and as a synthesizable model in the sd_wm8731 bench.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit slave address (0x34 write byte / 0x35 read byte).
- REG_NUM, 32, number of 8-bit registers; valid address range 0x0000..REG_NUM-1.

Ports:
- clk  input  1  system clock; must be at least 16x the SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- scl_in  input  1  SCL pin level, asynchronous.
- sda_in  input  1  SDA pin level, asynchronous.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- wr_en  output  1  one-clk pulse when a data byte is committed.
- wr_addr  output  16  register address of the committed byte.
- wr_data  output  8  committed data byte.
- busy  output  1  high from an addressed START until STOP.

Behaviour:
- Reset: all outputs 0, register file 0x00, state IDLE, address pointer 0x0000. Reset asserted mid-transaction releases SDA immediately.
- Input sync: scl_in and sda_in pass through 2-flop synchronizers. Edges come from a third stage. Pin-to-decision latency is 3 clk.
- Line events:
  - START (incl. repeated): SDA falls while SCL high. Goes to DEV from any state and clears the bit counter.
  - STOP: SDA rises while SCL high. Goes to IDLE from any state; sda_oe=0, busy=0.
- Sampling: data bits are sampled MSB first on the SCL rising edge. sda_oe changes only on SCL falling edges.
- States: IDLE, DEV, DEV_ACK, ADDR_H, ADDR_H_ACK, ADDR_L, ADDR_L_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- DEV: after 8 bits, compare bits[7:1] with DEV_ADDR.
  - Match: drive ACK (sda_oe=1) from the 8th falling edge to the 9th falling edge; set busy.
  - Mismatch: go to IGNORE; no ACK, sda_oe stays 0 until STOP or START.
- R/W=0 path: ADDR_H, then ADDR_L. Each byte is ACKed and the pointer is loaded. Then WDATA repeats until STOP or START.
- WDATA, in range (pointer < REG_NUM):
  - Store the byte and pulse wr_en for 1 clk, 1 clk after the 8th bit is sampled.
  - wr_addr = pointer and wr_data = byte, both held until the next strobe.
  - ACK, then pointer+1 (16-bit wrap 0xFFFF->0x0000).
- WDATA, out of range: NACK (sda_oe=0), no wr_en, pointer unchanged, then IGNORE.
- R/W=1 path: after the DEV ACK, on the 9th falling edge load reg[pointer] (0xFF if out of range) into the shifter.
  - Drive each bit on successive falling edges: sda_oe = ~bit.
  - After bit 0, release SDA on the 8th falling edge.
  - Sample the master ACK on the 9th rising edge.
  - ACK (0): pointer+1, load the next byte.
  - NACK (1): go to IGNORE.
- Repeated START after the address bytes keeps the pointer; this is the standard random-read sequence.
- ADDR_H/ADDR_L are always ACKed, even if out of range; the range check applies at data time.
- SCL held high or low indefinitely: hold state, no timeout.
- Simultaneous START/STOP detection with a bit edge: START/STOP takes priority.

Test Plan:
- Write {0x34,0x00,0x08,0x15} + STOP:
  - ACK on all 4 bytes.
  - Exactly one wr_en with wr_addr=0x0008, wr_data=0x15.
  - busy returns to 0 after STOP.
- Device byte 0x36 followed by 3 bytes:
  - sda_oe stays 0 throughout, no wr_en, busy=0.
  - A following valid 0x34 transaction is ACKed.
- Burst {0x34,0x00,0x0C,0x00,0xAA}:
  - Two wr_en pulses: (0x000C,0x00) then (0x000D,0xAA).
- Random read after the burst {0x34,0x00,0x0C}, repeated START, 0x35:
  - Reads 0x00 with master ACK, then 0xAA with master NACK.
  - SDA released after the NACK.
- Out-of-range write {0x34,0x01,0x00,0x55}:
  - Address bytes ACKed, data byte NACKed, no wr_en.
  - Read of that address returns 0xFF.
- rst_n pulsed low during bit 4 of a read data byte:
  - sda_oe=0 within the reset assertion, register file 0x00, state IDLE.
  - Next transaction behaves as from reset.
